ariane_wakeup_seq: RTL and testbench

ARIANE_WAKEUP_SEQ -- requirements
Module: ariane_wakeup_seq

---
 rtl/ariane_wakeup_pkg.sv | 26 ++
 rtl/ariane_wakeup_seq.sv | 110 +++++++++++
 tb/tb_ariane_wakeup_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ariane_wakeup_pkg.sv
// Shared definitions for the core wakeup sequencer: FSM state encoding and
// the L15 interrupt-return fields that identify a wakeup.
package ariane_wakeup_pkg;

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_WAIT_WAKE = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_PARKED    = 3'd4
   } wake_state_e;

   // rtrn_data_i[17:16] interrupt type and rtrn_data_i[5:0] interrupt code
   localparam logic [1:0] WAKE_RET_TYPE = 2'b01;
   localparam logic [5:0] WAKE_INT_CODE = 6'b000001;

   localparam int unsigned CNT_W = 16;

   function automatic logic is_wakeup(input logic       val,
                                      input logic       int_ret,
                                      input logic [1:0] ret_type,
                                      input logic [5:0] int_code);
      return val & int_ret & (ret_type == WAKE_RET_TYPE) & (int_code == WAKE_INT_CODE);
   endfunction

endpackage

// File: rtl/ariane_wakeup_seq.sv
// Holds the core in reset through SRAM init and until a wakeup interrupt
// (or override), then releases it and gates its L15 requests while parked.
module ariane_wakeup_seq
   import ariane_wakeup_pkg::*;
#(
   parameter int unsigned InitCycles    = 32768,
   parameter int unsigned ReleaseCycles = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        override_i,
   input  logic        rtrn_val_i,
   input  logic        rtrn_int_i,
   input  logic [17:0] rtrn_data_i,
   input  logic        quiesce_i,
   input  logic        req_val_i,
   input  logic        req_ack_i,
   output logic        req_val_o,
   output logic        core_rst_no,
   output logic [2:0]  state_o
);

   localparam logic [CNT_W-1:0] InitLast    = CNT_W'(InitCycles - 1);
   localparam logic [CNT_W-1:0] ReleaseLast = CNT_W'(ReleaseCycles - 1);

   wake_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             wake_flag_q, wake_flag_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             wake_det, wake_go;

   // Payload bits between the type and code fields carry nothing we need.
   logic unused_data;
   assign unused_data = ^rtrn_data_i[15:6];

   assign wake_det = is_wakeup(rtrn_val_i, rtrn_int_i, rtrn_data_i[17:16], rtrn_data_i[5:0]);
   // A wakeup seen this very cycle counts, so it is never lost to the flag's latency.
   assign wake_go  = wake_flag_q | wake_det | override_i;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wake_flag_d = wake_flag_q | wake_det;

      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_inc;
            if (cnt_q >= InitLast) begin
               if (wake_go) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT_WAKE;
               end
            end
         end
         ST_WAIT_WAKE: begin
            if (wake_go) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end
         end
         ST_RELEASE: begin
            cnt_d = cnt_inc;
            if (cnt_q >= ReleaseLast) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // An outstanding request must be acked before the port may park.
            if (quiesce_i && (!req_val_i || req_ack_i)) begin
               state_d = ST_PARKED;
            end
         end
         ST_PARKED: begin
            if (!quiesce_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase

      core_rst_n_d = (state_d == ST_RUN) || (state_d == ST_PARKED);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         wake_flag_q  <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wake_flag_q  <= wake_flag_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   assign core_rst_no = core_rst_n_q;
   assign req_val_o   = req_val_i & (state_q == ST_RUN);
   assign state_o     = state_q;

endmodule

// File: tb/tb_ariane_wakeup_seq.sv
// Self-checking bench for ariane_wakeup_seq: directed scenarios plus random
// traffic compared against a timeline-based reference model.
module tb_ariane_wakeup_seq;
   import ariane_wakeup_pkg::*;

   localparam int INIT_C = 8;
   localparam int REL_C  = 5;
   localparam int NEVER  = 1 << 30;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        override_in = 1'b0;
   logic        rtrn_val = 1'b0;
   logic        rtrn_int = 1'b0;
   logic [17:0] rtrn_data = '0;
   logic        quiesce = 1'b0;
   logic        req_val = 1'b0;
   logic        req_ack = 1'b0;
   logic        req_val_o;
   logic        core_rst_no;
   logic [2:0]  state_o;

   ariane_wakeup_seq #(
      .InitCycles   (INIT_C),
      .ReleaseCycles(REL_C)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .override_i (override_in),
      .rtrn_val_i (rtrn_val),
      .rtrn_int_i (rtrn_int),
      .rtrn_data_i(rtrn_data),
      .quiesce_i  (quiesce),
      .req_val_i  (req_val),
      .req_ack_i  (req_ack),
      .req_val_o  (req_val_o),
      .core_rst_no(core_rst_no),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: edges since reset, first wakeup edge, run/park phase.
   int         t          = 0;
   int         wake_first = -1;
   bit         m_ov       = 1'b0;
   logic [2:0] m_state    = ST_INIT;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   function automatic int release_start();
      if (m_ov)           return INIT_C;
      if (wake_first < 0) return NEVER;
      return (wake_first > INIT_C) ? wake_first : INIT_C;
   endfunction

   function automatic bit m_released();
      return (m_state == ST_RUN) || (m_state == ST_PARKED);
   endfunction

   task automatic model_edge(input bit is_wake, input bit qu, input bit rv, input bit ra);
      int rs;
      int run_at;
      t++;
      if (is_wake && wake_first < 0) wake_first = t;
      rs     = release_start();
      run_at = rs + REL_C;
      if (t < INIT_C)                                    m_state = ST_INIT;
      else if (t < rs)                                   m_state = ST_WAIT_WAKE;
      else if (t < run_at)                               m_state = ST_RELEASE;
      else if (t == run_at)                              m_state = ST_RUN;
      else if (m_state == ST_RUN && qu && (!rv || ra))   m_state = ST_PARKED;
      else if (m_state == ST_PARKED && !qu)              m_state = ST_RUN;
   endtask

   // kind: 0 idle, 1 valid wakeup, 2 wrong code, 3 wrong type, 4 not an int return, 5 not valid
   task automatic drive_rtrn(input int kind);
      logic [9:0] mid;
      mid       = 10'($urandom);
      rtrn_val  = 1'b1;
      rtrn_int  = 1'b1;
      rtrn_data = {WAKE_RET_TYPE, mid, WAKE_INT_CODE};
      case (kind)
         0: begin rtrn_val = 1'b0; rtrn_int = 1'($urandom); rtrn_data = 18'($urandom); end
         2: rtrn_data[5:0]   = 6'b000010;
         3: rtrn_data[17:16] = 2'b10;
         4: rtrn_int = 1'b0;
         5: rtrn_val = 1'b0;
         default: ;
      endcase
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input int kind, input bit qu, input bit rv, input bit ra);
      drive_rtrn(kind);
      quiesce = qu;
      req_val = rv;
      req_ack = ra;
      #1 chk("req_val_o", req_val_o, rv && (m_state == ST_RUN));
      @(posedge clk);
      model_edge(kind == 1, qu, rv, ra);
      #1;
      chk("state_o", state_o, m_state);
      chk("core_rst_no", core_rst_no, m_released());
      @(negedge clk);
   endtask

   task automatic do_reset(input bit ov, input bit hold_req);
      rst         = 1'b1;
      override_in = ov;
      req_val     = hold_req;
      #1;
      chk("rst_state", state_o, ST_INIT);
      chk("rst_core_rst_no", core_rst_no, 1'b0);
      chk("rst_req_val_o", req_val_o, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rtrn_val   = 1'b0;
      rtrn_int   = 1'b0;
      quiesce    = 1'b0;
      req_val    = 1'b0;
      req_ack    = 1'b0;
      rst        = 1'b0;
      t          = 0;
      wake_first = -1;
      m_ov       = ov;
      m_state    = ST_INIT;
   endtask

   initial begin
      // Wakeup after INIT: WAIT_WAKE at 8, RELEASE at 21, core released at 21+REL_C.
      do_reset(1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step(0, 1'b0, 1'b0, 1'b0);
         if (t == INIT_C) chk("wait_wake_at_init_end", state_o, ST_WAIT_WAKE);
      end
      step(1, 1'b0, 1'b0, 1'b0);
      chk("release_at_21", state_o, ST_RELEASE);
      for (int i = 0; i < REL_C + 2; i++) begin
         step(0, 1'b0, 1'b1, 1'b0);
         if (t == 20 + REL_C) chk("core_held_last_release", core_rst_no, 1'b0);
         if (t == 21 + REL_C) chk("core_released", core_rst_no, 1'b1);
      end

      // Wakeup during INIT is remembered: INIT goes straight to RELEASE.
      do_reset(1'b0, 1'b0);
      for (int i = 1; i <= INIT_C + REL_C + 3; i++) begin
         step((t == 2) ? 1 : 0, 1'b0, 1'b0, 1'b0);
         if (t == INIT_C) chk("init_to_release", state_o, ST_RELEASE);
      end

      // Override with only wrong-code returns reaches RUN after INIT+RELEASE.
      do_reset(1'b1, 1'b0);
      for (int i = 1; i <= INIT_C + REL_C; i++) step(2, 1'b0, 1'b0, 1'b0);
      chk("override_run", state_o, ST_RUN);

      // Parking waits for the pending request to be acked.
      for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b1, 1'b0);
      chk("park_blocked", state_o, ST_RUN);
      step(0, 1'b1, 1'b1, 1'b1);
      chk("parked_after_ack", state_o, ST_PARKED);
      step(1, 1'b1, 1'b1, 1'b0);
      step(0, 1'b0, 1'b1, 1'b0);
      chk("unpark", state_o, ST_RUN);

      // Reset mid-RUN with a live request, then the full sequence again.
      req_val = 1'b1;
      #1 chk("run_req_passes", req_val_o, 1'b1);
      @(negedge clk);
      do_reset(1'b0, 1'b1);
      for (int i = 1; i <= 25; i++) step((t == 11) ? 1 : 0, 1'b0, 1'b1, 1'b0);

      // Near-miss returns never wake the core.
      do_reset(1'b0, 1'b0);
      for (int i = 1; i <= 40; i++) step(2 + (i % 4), 1'b0, 1'b0, 1'b0);
      chk("no_false_wake", state_o, ST_WAIT_WAKE);

      // Random traffic against the model.
      for (int seg = 0; seg < 8; seg++) begin
         do_reset(($urandom_range(0, 3) == 0), 1'($urandom));
         for (int i = 0; i < 80; i++) begin
            int kind;
            kind = ($urandom_range(0, 24) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 5));
            step(kind, ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 3) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
